// File: rtl/shift_mix_asic_if.sv
// Handshake/bus bundle between SubBytes, ShiftRows+MixColumns and AddRoundKey.
// master drives in_data/in_ready/last_round; slave returns out_data/out_ready/busy/drop.
interface shift_mix_asic_if;
  logic [0:127] in_data;
  logic         in_ready;
  logic         last_round;
  logic [0:127] out_data;
  logic         out_ready;
  logic         busy;
  logic         drop;

  modport master (
    output in_data, in_ready, last_round,
    input  out_data, out_ready, busy, drop
  );

  modport slave (
    input  in_data, in_ready, last_round,
    output out_data, out_ready, busy, drop
  );
endinterface

// File: rtl/shift_mix_asic.sv
// AES round stage: ShiftRows on accept, then MixColumns COLS_PER_CYCLE columns/clk.
// Ports: clk, reset (sync, active-low), bus (slave). Option: SHIFT_MIX_HOLD_EN.
module shift_mix_asic #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic           clk,
  input logic           reset,
  shift_mix_asic_if.slave bus
);

  localparam int         N        = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] CNT_LAST = 2'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    COL,
    DONE
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [0:127] work_q, work_d;
  logic         last_q, last_d;
  logic [0:127] out_data_q, out_data_d;
  logic         out_ready_q, out_ready_d;
  logic         busy_q, busy_d;
  logic         drop_q, drop_d;

  logic [0:127] mixed;
  logic         start;
  logic [0:127] start_data;
  logic         start_last;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] s0, s1, s2, s3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    s0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    s1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    s2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    s3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {s0, s1, s2, s3};
  endfunction

  // byte k = 4c+r; row r rotates left by r columns
  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  // columns of the current group, mixed unless final round
  always_comb begin
    mixed = work_q;
    for (int c = 0; c < 4; c++) begin
      if (!last_q && (2'(c / COLS_PER_CYCLE) == cnt_q)) begin
        mixed[32*c +: 32] = mix_col(work_q[32*c +: 32]);
      end
    end
  end

`ifdef SHIFT_MIX_HOLD_EN
  logic [0:127] hold_q, hold_d;
  logic         hold_last_q, hold_last_d;
  logic         hold_vld_q, hold_vld_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_vld_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_vld_q  <= hold_vld_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_ready_d = 1'b0;
    busy_d      = busy_q;
    drop_d      = 1'b0;
    start       = 1'b0;
    start_data  = bus.in_data;
    start_last  = bus.last_round;
`ifdef SHIFT_MIX_HOLD_EN
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_vld_d  = hold_vld_q;
`endif

    unique case (state_q)
      IDLE: begin
        start = bus.in_ready;
      end
      COL: begin
        work_d = mixed;
        cnt_d  = cnt_q + 2'd1;
        if (bus.in_ready) begin
`ifdef SHIFT_MIX_HOLD_EN
          if (!hold_vld_q) begin
            hold_d      = bus.in_data;
            hold_last_d = bus.last_round;
            hold_vld_d  = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
`else
          drop_d = 1'b1;
`endif
        end
        if (cnt_q == CNT_LAST) begin
          out_data_d  = mixed;
          out_ready_d = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = 2'd0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef SHIFT_MIX_HOLD_EN
        // buffered job wins; a fresh input refills the freed slot
        if (hold_vld_q) begin
          start       = 1'b1;
          start_data  = hold_q;
          start_last  = hold_last_q;
          hold_vld_d  = bus.in_ready;
          hold_d      = bus.in_data;
          hold_last_d = bus.last_round;
        end else begin
          start = bus.in_ready;
        end
`else
        start = bus.in_ready;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      work_d  = shift_rows(start_data);
      last_d  = start_last;
      cnt_d   = 2'd0;
      busy_d  = 1'b1;
      state_d = COL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      work_q      <= '0;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_ready_q <= out_ready_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ready = out_ready_q;
  assign bus.busy      = busy_q;
  assign bus.drop      = drop_q;

endmodule

// File: tb/tb_shift_mix_asic.sv
// Directed bench for shift_mix_asic at COLS_PER_CYCLE = 1, 2, 4.
// Covers reset, latency, final round, back-to-back, collision and mid-job reset.
module tb_shift_mix_asic;

  logic         clk = 1'b0;
  logic         reset;
  logic [0:127] in_data;
  logic         in_ready;
  logic         last_round;

  always #5 clk = ~clk;

  shift_mix_asic_if if1 ();
  shift_mix_asic_if if2 ();
  shift_mix_asic_if if4 ();

  assign if1.in_data    = in_data;
  assign if1.in_ready   = in_ready;
  assign if1.last_round = last_round;
  assign if2.in_data    = in_data;
  assign if2.in_ready   = in_ready;
  assign if2.last_round = last_round;
  assign if4.in_data    = in_data;
  assign if4.in_ready   = in_ready;
  assign if4.last_round = last_round;

  shift_mix_asic #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );
  shift_mix_asic #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .reset(reset), .bus(if2)
  );
  shift_mix_asic #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .bus(if4)
  );

`ifdef SHIFT_MIX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  localparam logic [127:0] V0   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] MIX0 = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] SR0  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [127:0] din;
    logic         lr;
    logic [127:0] dout;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int l1, l2, l4, c1, c2, c4, dseen, first, second, nev;
    logic [127:0] r1, r2, r4, v_first, v_second;

    tbl[0] = '{V0, 1'b0, MIX0};
    tbl[1] = '{V0, 1'b1, SR0};
    tbl[2] = '{128'h0100_0000_0000_0000_0000_0000_0000_0000, 1'b0,
               128'h0201_0103_0000_0000_0000_0000_0000_0000};
    tbl[3] = '{128'h0001_0000_0000_0000_0000_0000_0000_0000, 1'b0,
               128'h0000_0000_0000_0000_0000_0000_0302_0101};
    tbl[4] = '{{128{1'b1}}, 1'b0, {128{1'b1}}};

    reset      = 1'b0;
    in_data    = '0;
    in_ready   = 1'b0;
    last_round = 1'b0;
    tick();
    in_ready = 1'b1;
    tick();
    tick();
    in_ready = 1'b0;
    check("rst_out_data", 128'(if1.out_data), 128'h0);
    check("rst_flags", 128'({if1.out_ready, if1.busy, if1.drop}), 128'h0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      in_data    = tbl[i].din;
      last_round = tbl[i].lr;
      in_ready   = 1'b1;
      tick();
      in_ready = 1'b0;
      check($sformatf("busy_start%0d", i), 128'(if1.busy), 128'h1);
      l1 = -1; l2 = -1; l4 = -1;
      c1 = 0; c2 = 0; c4 = 0; dseen = 0;
      r1 = '0; r2 = '0; r4 = '0;
      for (int k = 1; k <= 6; k++) begin
        tick();
        if (if1.out_ready) begin c1++; if (l1 < 0) l1 = k; r1 = if1.out_data; end
        if (if2.out_ready) begin c2++; if (l2 < 0) l2 = k; r2 = if2.out_data; end
        if (if4.out_ready) begin c4++; if (l4 < 0) l4 = k; r4 = if4.out_data; end
        if (if1.drop || if2.drop || if4.drop) dseen++;
        if (k == 4) check($sformatf("busy_end%0d", i), 128'(if1.busy), 128'h0);
      end
      check($sformatf("lat%0d", i), 128'({8'(l1), 8'(l2), 8'(l4)}),
            128'h040201);
      check($sformatf("pulses%0d", i), 128'({8'(c1), 8'(c2), 8'(c4)}),
            128'h010101);
      check($sformatf("out1_%0d", i), r1, tbl[i].dout);
      check($sformatf("out2_%0d", i), r2, tbl[i].dout);
      check($sformatf("out4_%0d", i), r4, tbl[i].dout);
      check($sformatf("hold1_%0d", i), 128'(if1.out_data), tbl[i].dout);
      check($sformatf("nodrop%0d", i), 128'(dseen), 128'h0);
    end

    // back-to-back: second job accepted in DONE
    in_data    = V0;
    last_round = 1'b0;
    in_ready   = 1'b1;
    tick();
    in_ready = 1'b0;
    first = -1; second = -1; dseen = 0;
    v_first = '0; v_second = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      in_ready = 1'b0;
      if (if1.drop) dseen++;
      if (if1.out_ready) begin
        if (first < 0) begin
          first = k; v_first = if1.out_data;
          in_ready = 1'b1; last_round = 1'b1;
        end else if (second < 0) begin
          second = k; v_second = if1.out_data;
        end
      end
    end
    check("b2b_first", v_first, MIX0);
    check("b2b_gap", 128'(second - first), 128'd5);
    check("b2b_second", v_second, SR0);
    check("b2b_nodrop", 128'(dseen), 128'h0);

    // collision: inputs at E2 and E3 of an active job
    in_data    = V0;
    last_round = 1'b0;
    in_ready   = 1'b1;
    tick();
    in_ready = 1'b0;
    first = -1; second = -1; nev = 0;
    v_first = '0; v_second = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      in_ready = 1'b0;
      if (k == 1) begin
        in_ready = 1'b1; in_data = V0; last_round = 1'b1;
      end
      if (k == 2) begin
        check("col_drop_e2", 128'(if1.drop), HOLD ? 128'h0 : 128'h1);
        in_ready = 1'b1; in_data = '0; last_round = 1'b0;
      end
      if (k == 3) check("col_drop_e3", 128'(if1.drop), 128'h1);
      if (k == 4) check("col_drop_clr", 128'(if1.drop), 128'h0);
      if (if1.out_ready) begin
        nev++;
        if (first < 0) begin first = k; v_first = if1.out_data; end
        else if (second < 0) begin second = k; v_second = if1.out_data; end
      end
    end
    check("col_first_lat", 128'(first), 128'd4);
    check("col_first", v_first, MIX0);
    check("col_events", 128'(nev), HOLD ? 128'd2 : 128'd1);
    if (HOLD) begin
      check("col_second_gap", 128'(second - first), 128'd5);
      check("col_second", v_second, SR0);
    end

    // reset mid-job
    in_data    = V0;
    last_round = 1'b0;
    in_ready   = 1'b1;
    tick();
    in_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst_out_data", 128'(if1.out_data), 128'h0);
    check("mrst_flags", 128'({if1.out_ready, if1.busy}), 128'h0);
    nev = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (if1.out_ready || if1.busy) nev++;
    end
    check("mrst_quiet", 128'(nev), 128'h0);
    in_data    = tbl[3].din;
    last_round = 1'b0;
    in_ready   = 1'b1;
    tick();
    in_ready = 1'b0;
    first = -1; v_first = '0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (if1.out_ready && first < 0) begin first = k; v_first = if1.out_data; end
    end
    check("mrst_lat", 128'(first), 128'd4);
    check("mrst_out", v_first, tbl[3].dout);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_mix_asic.md
Name: shift_mix_asic

Overview:
- Round stage directly downstream of the SubBytes stage in the pipelined AES-256 encryptor.
- Consumes the 128-bit SubBytes result on its in_ready pulse, applies ShiftRows, then MixColumns.
- MixColumns is skipped in the final round (last_round=1).
- Processes COLS_PER_CYCLE columns per cycle and emits the full state with a one-cycle out_ready pulse to the AddRoundKey stage.

Parameters:
- COLS_PER_CYCLE, 1, columns mixed per clock; legal values 1, 2, 4; N = 4/COLS_PER_CYCLE compute cycles.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- in_data  input  [0:127]  SubBytes output state; byte k = in_data[8k:8k+7], with row r = k%4 and column c = k/4 (FIPS-197 column-major)
- in_ready  input  1  one-cycle pulse: in_data valid
- last_round  input  1  sampled with in_ready; 1 = skip MixColumns
- out_data  output  [0:127]  round result, same byte ordering as in_data
- out_ready  output  1  one-cycle pulse: out_data valid
- busy  output  1  high while a job is in COL state
- drop  output  1  one-cycle pulse: an input was lost

Behaviour:
- Reset is synchronous and active-low on clk.
- While reset=0: state=IDLE, out_data=0, out_ready=0, busy=0, drop=0, column counter=0, work register=0, stored last_round=0, hold buffer empty.
- Reset asserted mid-job discards the job; no out_ready is produced for it.
- FSM states: IDLE, COL, DONE.
- IDLE: on in_ready=1, latch into the work register: w(r,c) = in(r,(c+r) mod 4) (ShiftRows). Also latch last_round, clear the counter, go to COL, busy=1.
- COL: each cycle, transform columns [cnt*CPC .. cnt*CPC+CPC-1] of the work register in place, then cnt += 1.
  - Mix (last_round=0): s0'=2a0^3a1^a2^a3, s1'=a0^2a1^3a2^a3, s2'=a0^a1^2a2^3a3, s3'=3a0^a1^a2^2a3.
  - xtime(b) = {b[1:7],0} ^ (b[0] ? 8'h1B : 0), with b[0] the MSB.
  - last_round=1: columns are left unchanged; the latency is identical.
  - On the cycle cnt reaches N-1: load the whole work register into out_data (single write; out_data never shows partial columns), set out_ready<=1, busy<=0, go to DONE.
- DONE: lasts one cycle; out_ready=1 throughout.
  - Next edge: out_ready<=0.
  - If in_ready=1 in DONE: accept it exactly as in IDLE and go to COL; otherwise go to IDLE.
- Latency: in_ready sampled at edge E0; out_ready is high in the cycle after edge E(N). With CPC=1, a job accepted at E0 gives out_ready high between E4 and E5.
- Throughput: one job per N+1 cycles.
- out_data holds its value until the next job completes.
- in_ready while in COL: input ignored, drop=1 for one cycle, current job unaffected (base build).
- in_ready is ignored while reset=0.

Optional Feature:
- Macro: SHIFT_MIX_HOLD_EN.
- Defined:
  - Adds a one-entry holding buffer (128-bit data plus last_round bit, plus a valid flag).
  - in_ready in COL with the buffer empty: capture into the buffer, no drop.
  - In DONE with the buffer valid: start the buffered job (applying ShiftRows at that point) and clear the buffer.
  - Buffer valid and a fresh in_ready in DONE: the buffered job starts first, and the fresh input goes into the freed buffer.
  - drop fires only when in_ready arrives in COL with the buffer already full.
  - Reset clears the buffer.
- Undefined: no buffer; any in_ready in COL fires drop as above.

Test Plan:
- Reset and latency, CPC=1: in_data=d42711aee0bf98f1b8b45de51e415230, last_round=0, in_ready pulse at E0 -> out_ready high for exactly one cycle after E4, out_data=046681e5e0cb199a48f8d37a2806264c; busy high E0..E4.
- Final round: same in_data with last_round=1 -> out_ready after E4, out_data=d4bf5d30e0b452aeb84111f11e2798e5.
- Back-to-back: second in_ready (same vector, last_round=1) during DONE -> second out_ready exactly 5 cycles after the first, correct value; no drop.
- Collision:
  - Base build: in_ready at E2 of an active job -> drop pulse, first result unchanged, no second out_ready.
  - With SHIFT_MIX_HOLD_EN: second result appears 5 cycles after the first; a third in_ready while the buffer is full -> drop.
- Reset mid-job: reset=0 at E2 for one cycle -> out_data=0, out_ready never asserts, busy=0. A new job afterwards completes normally.
- Parameter sweep: CPC=2 and CPC=4 with the vector 0 -> out_ready after E2 and E1 respectively, out_data=046681e5e0cb199a48f8d37a2806264c.
